// File: rtl/t07_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t     : fetch FSM states
//   NOP_INSTR_DEFAULT : instruction shown while nothing valid is held (addi x0,x0,0)
//   FAULT_MISALIGN / FAULT_TIMEOUT : encodings of fault_cause
package t07_fetch_pkg;

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  localparam logic FAULT_MISALIGN = 1'b0;
  localparam logic FAULT_TIMEOUT  = 1'b1;

endpackage

// File: rtl/t07_fetch_if.sv
// Instruction memory read bus.
//   mem_req   : read request, held until ack
//   mem_addr  : word-aligned read address, stable while mem_req
//   mem_ack   : read data valid this cycle
//   mem_rdata : read data
// master = fetch stage, slave = instruction memory.
interface t07_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/t07_fetch_timeout.sv
// Saturating cycle counter used to bound the wait for mem_ack.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to zero (wins over en)
//   en       : count one cycle
//   expired  : count has reached MAX-1, i.e. this is the MAX-th counted cycle
module t07_fetch_timeout #(
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] LIMIT = W'(MAX);
  localparam logic [W-1:0] LAST  = W'(MAX - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                     cnt_d = '0;
    else if (en && cnt_q != LIMIT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == LAST);
endmodule

// File: rtl/t07_instruction_fetch.sv
// Fetch stage: reads the word at pc, holds it for execute, and releases the
// PC (fetch_freeze low) for exactly one cycle per retired instruction.
// Misaligned PCs and missing memory acks raise a sticky fault.
//   clk, rst      : clock, synchronous active-high reset
//   pc            : current program counter
//   ex_busy       : execute stall, holds the current instruction
//   mem           : instruction memory read bus (master side)
//   instr         : current instruction, NOP when none held
//   instr_valid   : instr is fetched and not yet retired
//   retire        : instruction completes this cycle (combinational)
//   fetch_freeze  : PC freeze, low only on the retire cycle (combinational)
//   fault / fault_addr / fault_cause : sticky fault and its origin
module t07_instruction_fetch
  import t07_fetch_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = NOP_INSTR_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pc,
  input  logic         ex_busy,
  t07_fetch_if.master  mem,
  output logic [31:0]  instr,
  output logic         instr_valid,
  output logic         retire,
  output logic         fetch_freeze,
  output logic         fault,
  output logic [31:0]  fault_addr,
  output logic         fault_cause
);
  fetch_state_t state_q, state_d;
  logic         mem_req_q, mem_req_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic [31:0]  instr_q, instr_d;
  logic         instr_valid_q, instr_valid_d;
  logic         fault_q, fault_d;
  logic [31:0]  fault_addr_q, fault_addr_d;
  logic         fault_cause_q, fault_cause_d;
  logic         tmo_clr, tmo_en, tmo_expired;

  t07_fetch_timeout #(.MAX(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    fault_addr_d  = fault_addr_q;
    fault_cause_d = fault_cause_q;
    tmo_clr       = 1'b0;
    tmo_en        = 1'b0;
    case (state_q)
      START: begin
        if (pc[1:0] != 2'b00) begin
          state_d       = FAULT;
          fault_d       = 1'b1;
          fault_addr_d  = pc;
          fault_cause_d = FAULT_MISALIGN;
        end else begin
          // mem_req is registered, so raise it on entry to FETCH
          state_d    = FETCH;
          mem_addr_d = pc;
          mem_req_d  = 1'b1;
          tmo_clr    = 1'b1;
        end
      end
      FETCH: begin
        if (mem.mem_ack) begin
          state_d       = EXEC;
          instr_d       = mem.mem_rdata;
          instr_valid_d = 1'b1;
          mem_req_d     = 1'b0;
        end else if (tmo_expired) begin
          state_d       = FAULT;
          mem_req_d     = 1'b0;
          fault_d       = 1'b1;
          fault_addr_d  = mem_addr_q;
          fault_cause_d = FAULT_TIMEOUT;
        end else begin
          tmo_en = 1'b1;
        end
      end
      EXEC: begin
        if (!ex_busy) begin
          state_d       = START;
          instr_valid_d = 1'b0;
          instr_d       = NOP_INSTR;
        end
      end
      FAULT: begin
        mem_req_d     = 1'b0;
        instr_d       = NOP_INSTR;
        instr_valid_d = 1'b0;
      end
      default: state_d = START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= START;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      fault_addr_q  <= '0;
      fault_cause_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      fault_addr_q  <= fault_addr_d;
      fault_cause_q <= fault_cause_d;
    end
  end

  // Decoded so the PC advances on the very edge that ends the retire cycle.
  assign retire       = (state_q == EXEC) && !ex_busy;
  assign fetch_freeze = !retire;

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign instr        = instr_q;
  assign instr_valid  = instr_valid_q;
  assign fault        = fault_q;
  assign fault_addr   = fault_addr_q;
  assign fault_cause  = fault_cause_q;
endmodule
